// File: rtl/trigger_capture.sv
// Trigger-based logic-analyser capture controller: fills a circular sample memory
// with PRE_TRIG samples before a masked trigger match and the remainder after it.
module trigger_capture #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int MEMORY_SIZE = 2**ADDR_WIDTH,
    parameter int PRE_TRIG    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] probe_data,
    input  logic [DATA_WIDTH-1:0] trig_value,
    input  logic [DATA_WIDTH-1:0] trig_mask,
    input  logic                  read_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic                  read_enable,
    output logic                  triggered,
    output logic                  capture_done,
    output logic                  busy
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]         ONE_C  = CW'(1);
    localparam logic [CW-1:0]         PRE_C  = CW'(PRE_TRIG);
    localparam logic [CW-1:0]         POST_C = CW'(MEMORY_SIZE - PRE_TRIG);
    localparam logic [CW-1:0]         MEM_C  = CW'(MEMORY_SIZE);
    localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(MEMORY_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRETRIG = 3'd1,
        ARMED   = 3'd2,
        POST    = 3'd3,
        DONE    = 3'd4,
        READOUT = 3'd5
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] wptr_q;
    logic [ADDR_WIDTH-1:0] wptr_d;
    logic [CW-1:0]         pre_cnt_q;
    logic [CW-1:0]         post_cnt_q;
    logic [CW-1:0]         rd_cnt_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_waddr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic                  read_enable_q;
    logic                  triggered_q;
    logic                  capture_done_q;
    logic                  busy_q;
    logic                  trig_match;
    logic                  wr_active;

    // Wrap explicitly so non-power-of-two depths stay in range.
    assign wptr_d     = (wptr_q == LAST_A) ? {ADDR_WIDTH{1'b0}} : wptr_q + ADDR_WIDTH'(1);
    assign trig_match = (((probe_data ^ trig_value) & trig_mask) == {DATA_WIDTH{1'b0}});
    assign wr_active  = (state_q == PRETRIG) || (state_q == ARMED) || (state_q == POST);

    // Capture FSM with registered memory-write port and status outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            wptr_q         <= {ADDR_WIDTH{1'b0}};
            pre_cnt_q      <= {CW{1'b0}};
            post_cnt_q     <= {CW{1'b0}};
            rd_cnt_q       <= {CW{1'b0}};
            mem_we_q       <= 1'b0;
            mem_waddr_q    <= {ADDR_WIDTH{1'b0}};
            mem_wdata_q    <= {DATA_WIDTH{1'b0}};
            waddr_q        <= {ADDR_WIDTH{1'b0}};
            read_enable_q  <= 1'b0;
            triggered_q    <= 1'b0;
            capture_done_q <= 1'b0;
            busy_q         <= 1'b0;
        end else if (abort) begin
            state_q        <= IDLE;
            mem_we_q       <= 1'b0;
            read_enable_q  <= 1'b0;
            triggered_q    <= 1'b0;
            capture_done_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            mem_we_q <= wr_active;
            if (wr_active) begin
                mem_waddr_q <= wptr_q;
                mem_wdata_q <= probe_data;
                wptr_q      <= wptr_d;
            end
            case (state_q)
                IDLE: begin
                    if (arm) begin
                        wptr_q      <= {ADDR_WIDTH{1'b0}};
                        pre_cnt_q   <= {CW{1'b0}};
                        post_cnt_q  <= {CW{1'b0}};
                        triggered_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= (PRE_TRIG == 0) ? ARMED : PRETRIG;
                    end
                end
                PRETRIG: begin
                    pre_cnt_q <= pre_cnt_q + ONE_C;
                    if (pre_cnt_q == PRE_C - ONE_C) begin
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    // The matching sample is itself the first post-trigger write.
                    if (trig_match) begin
                        triggered_q <= 1'b1;
                        post_cnt_q  <= ONE_C;
                        if (POST_C == ONE_C) begin
                            state_q        <= DONE;
                            waddr_q        <= wptr_q;
                            capture_done_q <= 1'b1;
                        end else begin
                            state_q <= POST;
                        end
                    end
                end
                POST: begin
                    post_cnt_q <= post_cnt_q + ONE_C;
                    if (post_cnt_q == POST_C - ONE_C) begin
                        state_q        <= DONE;
                        waddr_q        <= wptr_q;
                        capture_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (read_req) begin
                        state_q       <= READOUT;
                        read_enable_q <= 1'b1;
                        rd_cnt_q      <= {CW{1'b0}};
                    end
                end
                READOUT: begin
                    rd_cnt_q <= rd_cnt_q + ONE_C;
                    if (rd_cnt_q == MEM_C - ONE_C) begin
                        state_q        <= IDLE;
                        read_enable_q  <= 1'b0;
                        capture_done_q <= 1'b0;
                        busy_q         <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_waddr    = mem_waddr_q;
    assign mem_wdata    = mem_wdata_q;
    assign waddr        = waddr_q;
    assign read_enable  = read_enable_q;
    assign triggered    = triggered_q;
    assign capture_done = capture_done_q;
    assign busy         = busy_q;

endmodule

// File: doc/trigger_capture.md
TRIGGER_CAPTURE -- requirements
Module: trigger_capture

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: probe sample width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: sample memory address width.
REQ-003 SHALL have parameter MEMORY_SIZE, default 2**ADDR_WIDTH: sample memory depth.
REQ-004 SHALL have parameter PRE_TRIG, default 4: pre-trigger sample count, 0 <= PRE_TRIG < MEMORY_SIZE.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-006 SHALL have port reset  input  1  synchronous, active-low reset (reset==0 resets at the next posedge).
REQ-007 SHALL have port arm  input  1  one-cycle pulse that starts a capture.
REQ-008 SHALL have port abort  input  1  returns to IDLE from any state.
REQ-009 SHALL have port probe_data  input  DATA_WIDTH  sampled signals.
REQ-010 SHALL have port trig_value  input  DATA_WIDTH  trigger compare value.
REQ-011 SHALL have port trig_mask  input  DATA_WIDTH  trigger compare mask (1 = bit compared).
REQ-012 SHALL have port read_req  input  1  pulse requesting readout of a completed capture.
REQ-013 SHALL have port mem_we  output  1  sample memory write enable.
REQ-014 SHALL have port mem_waddr  output  ADDR_WIDTH  sample memory write address.
REQ-015 SHALL have port mem_wdata  output  DATA_WIDTH  sample memory write data.
REQ-016 SHALL have port waddr  output  ADDR_WIDTH  address of last written sample, for the read stage.
REQ-017 SHALL have port read_enable  output  1  read-stage advance strobe.
REQ-018 SHALL have port triggered  output  1  trigger seen in current capture.
REQ-019 SHALL have port capture_done  output  1  memory holds a complete capture.
REQ-020 SHALL have port busy  output  1  state != IDLE.

Function
REQ-021 SHALL implement states IDLE, PRETRIG, ARMED, POST, DONE, READOUT.
REQ-022 SHALL register mem_we, mem_waddr, mem_wdata: probe sample of cycle N written with mem_we=1 in cycle N+1.
REQ-023 SHALL keep write pointer wptr; each write uses mem_waddr=wptr, then wptr increments modulo MEMORY_SIZE.
REQ-024 IDLE: mem_we=0; arm=1 -> wptr=0, pre counter=0, triggered=0; next state PRETRIG (ARMED if PRE_TRIG==0).
REQ-025 PRETRIG: write every cycle; after PRE_TRIG writes -> ARMED; trigger ignored in PRETRIG.
REQ-026 ARMED: write every cycle, wrapping; trigger match = ((probe_data ^ trig_value) & trig_mask) == 0.
REQ-027 On match in ARMED: that sample is the first POST sample; triggered=1 next cycle; state -> POST.
REQ-028 POST: exactly MEMORY_SIZE-PRE_TRIG writes total including trigger sample; then -> DONE.
REQ-029 trig_mask==0 SHALL trigger on the first ARMED cycle.
REQ-030 On entering DONE: mem_we=0, waddr=address of final write, capture_done=1; waddr held until next arm.
REQ-031 DONE: read_req=1 -> READOUT; read_enable=1 for exactly MEMORY_SIZE consecutive cycles, then -> IDLE, capture_done=0.
REQ-032 arm ignored outside IDLE; read_req ignored outside DONE.
REQ-033 abort=1 in any state -> IDLE next cycle: mem_we=0, read_enable=0, capture_done=0, triggered=0; abort overrides arm and read_req in same cycle.
REQ-034 Counters SHALL be ADDR_WIDTH+1 bits so MEMORY_SIZE counts without overflow.

Reset
REQ-035 reset==0 at posedge -> state IDLE, wptr=0, waddr=0, mem_waddr=0, mem_wdata=0, mem_we=0, read_enable=0, triggered=0, capture_done=0, busy=0.
REQ-036 reset SHALL override abort, arm and read_req; reset mid-capture discards the capture.

Verification (DATA_WIDTH=8, ADDR_WIDTH=4, MEMORY_SIZE=16, PRE_TRIG=4)
REQ-037 probe=counter 0,1,2..., mask=FF, value=0x0A, arm at t0 -> writes 0x00..0x0A..0x15 at addr 0..15 then 0..5, done; waddr=5, triggered=1.
REQ-038 Match present at 2nd sample (during PRETRIG) -> ignored; trigger taken on first match in ARMED.
REQ-039 mask=00, arm -> 4 pre + 12 post writes, capture_done after 16 writes, waddr=15.
REQ-040 DONE then read_req pulse -> read_enable high exactly 16 cycles, then busy=0, capture_done=0.
REQ-041 abort during POST -> next cycle IDLE, mem_we=0, triggered=0; arm then restarts at wptr=0.
REQ-042 reset=0 during READOUT -> read_enable=0 next cycle, all outputs at REQ-035 values.
